reduceron_run_ctrl: RTL and testbench
=====================================

REDUCERON_RUN_CTRL -- requirements
Module: reduceron_run_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  RESET_HOLD  4  cycles core_rst_n is held low before each run (min 1)
  TIMEOUT  32'hFFFF_FFFF  run-cycle limit before abort
  FIFO_DEPTH  8  io-write capture FIFO entries (power of 2, min 2)
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  CLOCK_50  in  1  sole clock, 50 MHz, rising edge
  reset_n  in  1  synchronous active-low reset
  start  in  1  one-cycle run request (debounced upstream)
  core_rst_n  out  1  reset to Reduceron core, active low
  core_finish  in  1  core finished, result valid this cycle
  core_result  in  17  core result
  core_iowrite  in  1  core io write strobe
  core_ioaddr  in  14  io write address
  core_iowd  in  14  io write data
  busy  out  1  high in RESET_CORE or RUN
  result  out  17  latched result
  result_valid  out  1  result holds the current run's value
  timed_out  out  1  last run aborted by timeout
  cycles  out  32  run cycle count, saturating
  io_valid  out  1  FIFO non-empty
  io_ready  in  1  consumer pop; pop occurs when io_valid and io_ready are both high
  io_data  out  28  FIFO head {addr[13:0], data[13:0]}
  io_overflow  out  1  sticky: an io write was dropped

Function
REQ-003 FSM states SHALL be IDLE, RESET_CORE, RUN, DONE, TIMEOUT.
REQ-004 start in IDLE, DONE or TIMEOUT SHALL enter RESET_CORE and, in the same edge, clear result_valid, timed_out, cycles, io_overflow and the FIFO.
REQ-005 start in RESET_CORE or RUN SHALL be ignored.
REQ-006 core_rst_n SHALL be 0 exactly RESET_HOLD cycles in RESET_CORE, then RUN is entered with core_rst_n=1.
REQ-007 core_rst_n SHALL be 0 in IDLE, DONE and TIMEOUT, and 1 only in RUN.
REQ-008 cycles SHALL increment once per RUN cycle, starting at 1 on the first RUN cycle, and saturate at 32'hFFFF_FFFF.
REQ-009 core_finish in RUN SHALL latch core_result into result, set result_valid and enter DONE on the next edge; cycles then includes the finish cycle.
REQ-010 When cycles==TIMEOUT with no core_finish, the FSM SHALL set timed_out and enter TIMEOUT, leaving result_valid=0.
REQ-011 core_finish coincident with the timeout condition SHALL resolve as finish (DONE, timed_out=0).
REQ-012 core_finish, core_iowrite and the core_* data inputs SHALL be ignored outside RUN.
REQ-013 core_iowrite in RUN SHALL push {core_ioaddr, core_iowd}; push on full SHALL drop the entry and set io_overflow.
REQ-014 Simultaneous push and pop when full SHALL both succeed with no overflow; simultaneous push and pop when empty SHALL leave io_valid=1 next cycle with the pushed entry.
REQ-015 The FIFO SHALL be first-word-fall-through with io_data registered and stable while io_valid=1 and io_ready=0.
REQ-016 The FIFO SHALL remain poppable in DONE and TIMEOUT, and SHALL be cleared only by reset or start.
REQ-017 busy SHALL be a registered decode of the state.

Reset
REQ-018 When reset_n=0 at a clock edge, the block SHALL enter IDLE with core_rst_n=0, busy=0, result=0, result_valid=0, timed_out=0, cycles=0, io_valid=0, io_data=0, io_overflow=0, and FIFO pointers cleared.
REQ-019 Reset SHALL take priority over start, core_finish and core_iowrite in the same cycle, including reset mid-RUN.

Structure
REQ-020 A shared package SHALL hold the state enumeration, IO_ENTRY_W=28, RESULT_W=17 and CYCLE_W=32.
REQ-021 The FIFO SHALL be the sub-module run_io_fifo (parameter DEPTH) with a sync clear input; the FSM and counters SHALL reside in reduceron_run_ctrl.

Verification
REQ-022 The bench SHALL cover: RESET_HOLD=4, start then core_finish with core_result=17'h1ABCD on the 10th RUN cycle -> core_rst_n low exactly 4 cycles, result=17'h1ABCD, result_valid=1, cycles=10, state DONE.
REQ-023 The bench SHALL cover: TIMEOUT=20, no core_finish -> timed_out=1 after RUN cycle 20, result_valid=0, core_rst_n=0; a following start clears timed_out.
REQ-024 The bench SHALL cover: FIFO_DEPTH=8, 10 iowrites with io_ready=0 -> first 8 entries retained in order, io_overflow=1; drain yields the entries {addr=i, data=~i} for i=0..7.
REQ-025 The bench SHALL cover: core_finish coincident with the timeout condition -> DONE, result latched, timed_out=0.
REQ-026 The bench SHALL cover: start pulse mid-RUN -> ignored, cycles continues incrementing; reset_n=0 mid-RUN -> all outputs at reset values on the next cycle.
REQ-027 The bench SHALL cover: FIFO full with push and pop in the same cycle -> occupancy stays 8, no overflow, io_data advances to the next entry.

Source files
------------

// File: rtl/reduceron_run_ctrl_pkg.sv
// Shared types and widths for the Reduceron run controller.
// Holds the run-state enumeration, bus widths and a saturating increment.
package reduceron_run_ctrl_pkg;

  localparam int IO_ENTRY_W = 28;
  localparam int RESULT_W   = 17;
  localparam int CYCLE_W    = 32;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RESET_CORE = 3'd1,
    ST_RUN        = 3'd2,
    ST_DONE       = 3'd3,
    ST_TIMEOUT    = 3'd4
  } run_state_e;

  function automatic logic [CYCLE_W-1:0] sat_inc(input logic [CYCLE_W-1:0] v);
    return (v == {CYCLE_W{1'b1}}) ? v : v + CYCLE_W'(1);
  endfunction

endpackage

// File: rtl/run_io_fifo.sv
// First-word-fall-through capture FIFO for core io writes.
// The head entry is registered, so io_data holds steady until it is popped.
module run_io_fifo
  import reduceron_run_ctrl_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                  CLOCK_50,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  push,
  input  logic                  pop,
  input  logic [IO_ENTRY_W-1:0] push_data,
  output logic                  io_valid,
  output logic [IO_ENTRY_W-1:0] io_data,
  output logic                  overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [IO_ENTRY_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_next_s;
  logic [CNT_W-1:0]      count_r;
  logic [CNT_W-1:0]      count_next_s;
  logic                  full_s;
  logic                  pop_s;
  logic                  push_ok_s;
  logic [IO_ENTRY_W-1:0] head_next_s;

  // Occupancy bookkeeping and the value the head register takes next
  always_comb begin
    full_s        = (count_r == CNT_W'(DEPTH));
    pop_s         = io_valid && pop;
    push_ok_s     = push && (!full_s || pop_s);
    overflow      = push && full_s && !pop_s;
    rd_ptr_next_s = pop_s ? rd_ptr_r + PTR_W'(1) : rd_ptr_r;
    count_next_s  = count_r + CNT_W'(push_ok_s) - CNT_W'(pop_s);
    // An entry written into an otherwise empty queue bypasses storage into the head
    if (count_next_s == {CNT_W{1'b0}}) begin
      head_next_s = {IO_ENTRY_W{1'b0}};
    end else if ((count_r - CNT_W'(pop_s)) == {CNT_W{1'b0}}) begin
      head_next_s = push_data;
    end else begin
      head_next_s = mem_r[rd_ptr_next_s];
    end
  end

  // Entry storage, no reset needed
  always_ff @(posedge CLOCK_50) begin
    if (reset_n && !clear && push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers, count and registered head
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n || clear) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      io_valid <= 1'b0;
      io_data  <= {IO_ENTRY_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      rd_ptr_r <= rd_ptr_next_s;
      count_r  <= count_next_s;
      io_valid <= (count_next_s != {CNT_W{1'b0}});
      io_data  <= head_next_s;
    end
  end

endmodule

// File: rtl/reduceron_run_ctrl.sv
// Run controller for a Reduceron core: resets it, runs it, captures its
// result or times it out, and buffers its io writes for a consumer.
module reduceron_run_ctrl
  import reduceron_run_ctrl_pkg::*;
#(
  parameter int          RESET_HOLD = 4,
  parameter logic [31:0] TIMEOUT    = 32'hFFFF_FFFF,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic                  CLOCK_50,
  input  logic                  reset_n,
  input  logic                  start,
  output logic                  core_rst_n,
  input  logic                  core_finish,
  input  logic [RESULT_W-1:0]   core_result,
  input  logic                  core_iowrite,
  input  logic [13:0]           core_ioaddr,
  input  logic [13:0]           core_iowd,
  output logic                  busy,
  output logic [RESULT_W-1:0]   result,
  output logic                  result_valid,
  output logic                  timed_out,
  output logic [CYCLE_W-1:0]    cycles,
  output logic                  io_valid,
  input  logic                  io_ready,
  output logic [IO_ENTRY_W-1:0] io_data,
  output logic                  io_overflow
);

  localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

  run_state_e        state_r;
  run_state_e        state_next_s;
  logic [HOLD_W-1:0] hold_cnt_r;
  logic              hold_done_s;
  logic              run_s;
  logic              start_ok_s;
  logic              fifo_push_s;
  logic              fifo_drop_s;
  logic              core_rst_n_next_s;
  logic              busy_next_s;

  // Control strobes derived from the current state
  always_comb begin
    run_s       = (state_r == ST_RUN);
    start_ok_s  = start && ((state_r == ST_IDLE) || (state_r == ST_DONE) || (state_r == ST_TIMEOUT));
    fifo_push_s = run_s && core_iowrite;
    hold_done_s = (hold_cnt_r == HOLD_W'(RESET_HOLD - 1));
  end

  // State register
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; a finish on the timeout cycle wins over the timeout
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE, ST_TIMEOUT: begin
        if (start) state_next_s = ST_RESET_CORE;
        else       state_next_s = state_r;
      end
      ST_RESET_CORE: begin
        if (hold_done_s) state_next_s = ST_RUN;
        else             state_next_s = ST_RESET_CORE;
      end
      ST_RUN: begin
        if (core_finish)          state_next_s = ST_DONE;
        else if (cycles == TIMEOUT) state_next_s = ST_TIMEOUT;
        else                      state_next_s = ST_RUN;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Output decode, registered below so it lines up with the state register
  always_comb begin
    core_rst_n_next_s = (state_next_s == ST_RUN);
    busy_next_s       = (state_next_s == ST_RESET_CORE) || (state_next_s == ST_RUN);
  end

  // Hold counter, cycle counter, result capture and status flags
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      hold_cnt_r   <= {HOLD_W{1'b0}};
      core_rst_n   <= 1'b0;
      busy         <= 1'b0;
      result       <= {RESULT_W{1'b0}};
      result_valid <= 1'b0;
      timed_out    <= 1'b0;
      cycles       <= {CYCLE_W{1'b0}};
      io_overflow  <= 1'b0;
    end else begin
      core_rst_n <= core_rst_n_next_s;
      busy       <= busy_next_s;
      if (start_ok_s) begin
        hold_cnt_r   <= {HOLD_W{1'b0}};
        result_valid <= 1'b0;
        timed_out    <= 1'b0;
        cycles       <= {CYCLE_W{1'b0}};
        io_overflow  <= 1'b0;
      end else begin
        if (state_r == ST_RESET_CORE) hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
        // Counting on entry to RUN makes the first RUN cycle read 1
        if (state_next_s == ST_RUN) cycles <= sat_inc(cycles);
        if (run_s && core_finish) begin
          result       <= core_result;
          result_valid <= 1'b1;
        end
        if (run_s && (state_next_s == ST_TIMEOUT)) timed_out <= 1'b1;
        if (fifo_drop_s) io_overflow <= 1'b1;
      end
    end
  end

  run_io_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .CLOCK_50 (CLOCK_50),
    .reset_n  (reset_n),
    .clear    (start_ok_s),
    .push     (fifo_push_s),
    .pop      (io_ready),
    .push_data({core_ioaddr, core_iowd}),
    .io_valid (io_valid),
    .io_data  (io_data),
    .overflow (fifo_drop_s)
  );

endmodule

// File: tb/tb_reduceron_run_ctrl.sv
// Bench for reduceron_run_ctrl: a queue-based model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_reduceron_run_ctrl;

  localparam int HOLD  = 4;
  localparam int TMO   = 20;
  localparam int DEPTH = 8;
  localparam int P_IDLE = 0, P_HOLD = 1, P_RUN = 2, P_DONE = 3, P_TO = 4;

  logic        CLOCK_50 = 1'b0;
  logic        reset_n, start, core_finish, core_iowrite, io_ready;
  logic [16:0] core_result;
  logic [13:0] core_ioaddr, core_iowd;
  logic        core_rst_n, busy, result_valid, timed_out, io_valid, io_overflow;
  logic [16:0] result;
  logic [31:0] cycles;
  logic [27:0] io_data;

  always #10 CLOCK_50 = ~CLOCK_50;

  reduceron_run_ctrl #(
    .RESET_HOLD(HOLD), .TIMEOUT(32'd20), .FIFO_DEPTH(DEPTH)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .start(start), .core_rst_n(core_rst_n),
    .core_finish(core_finish), .core_result(core_result), .core_iowrite(core_iowrite),
    .core_ioaddr(core_ioaddr), .core_iowd(core_iowd), .busy(busy), .result(result),
    .result_valid(result_valid), .timed_out(timed_out), .cycles(cycles),
    .io_valid(io_valid), .io_ready(io_ready), .io_data(io_data), .io_overflow(io_overflow)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Behavioural model: run phase, remaining hold cycles, counters and a queue
  int          m_phase;
  int          m_hold_left;
  logic [31:0] m_cycles;
  logic [16:0] m_result;
  bit          m_rvalid, m_tout, m_ovf;
  logic [27:0] m_q[$];

  task automatic model_step();
    bit pop;
    if (!reset_n) begin
      m_phase = P_IDLE; m_hold_left = 0; m_cycles = 32'd0; m_result = 17'd0;
      m_rvalid = 1'b0; m_tout = 1'b0; m_ovf = 1'b0; m_q.delete();
      return;
    end
    pop = (m_q.size() != 0) && io_ready;
    if (start && (m_phase == P_IDLE || m_phase == P_DONE || m_phase == P_TO)) begin
      m_phase = P_HOLD; m_hold_left = HOLD; m_rvalid = 1'b0; m_tout = 1'b0;
      m_cycles = 32'd0; m_ovf = 1'b0; m_q.delete();
      return;
    end
    if (pop) void'(m_q.pop_front());
    case (m_phase)
      P_HOLD: begin
        m_hold_left--;
        if (m_hold_left == 0) begin m_phase = P_RUN; m_cycles = 32'd1; end
      end
      P_RUN: begin
        if (core_iowrite) begin
          if (m_q.size() < DEPTH) m_q.push_back({core_ioaddr, core_iowd});
          else m_ovf = 1'b1;
        end
        if (core_finish) begin
          m_result = core_result; m_rvalid = 1'b1; m_phase = P_DONE;
        end else if (m_cycles == TMO) begin
          m_tout = 1'b1; m_phase = P_TO;
        end else if (m_cycles != 32'hFFFF_FFFF) begin
          m_cycles++;
        end
      end
      default: ;
    endcase
  endtask

  initial forever begin
    @(posedge CLOCK_50);
    model_step();
  end

  // Every-cycle comparison against the model
  initial forever begin
    @(negedge CLOCK_50);
    if (check_en) begin
      chk("core_rst_n", core_rst_n, m_phase == P_RUN);
      chk("busy", busy, (m_phase == P_HOLD) || (m_phase == P_RUN));
      chk("result", result, m_result);
      chk("result_valid", result_valid, m_rvalid);
      chk("timed_out", timed_out, m_tout);
      chk("cycles", cycles, m_cycles);
      chk("io_valid", io_valid, m_q.size() != 0);
      chk("io_overflow", io_overflow, m_ovf);
      if (m_q.size() != 0) chk("io_data", io_data, m_q[0]);
    end
  end

  task automatic begin_run(output int lows);
    start = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0;
    lows = 0;
    while (core_rst_n === 1'b0 && lows < 50) begin
      lows++;
      @(negedge CLOCK_50);
    end
  endtask

  task automatic wait_not_busy();
    int n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge CLOCK_50);
    end
    chk("wait_not_busy", busy, 32'd0);
  endtask

  initial begin
    int lows;
    int n;
    logic [13:0] a;
    reset_n = 1'b0; start = 1'b0; core_finish = 1'b0; core_result = 17'd0;
    core_iowrite = 1'b0; core_ioaddr = 14'd0; core_iowd = 14'd0; io_ready = 1'b0;
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    check_en = 1'b1;
    chk("rst core_rst_n", core_rst_n, 32'd0);
    chk("rst io_data", io_data, 32'd0);
    reset_n = 1'b1;
    @(negedge CLOCK_50);

    // Finish with 17'h1ABCD on the 10th RUN cycle
    begin_run(lows);
    chk("hold_len", lows, 32'd4);
    chk("first_run_cycle", cycles, 32'd1);
    repeat (9) @(negedge CLOCK_50);
    core_finish = 1'b1; core_result = 17'h1ABCD;
    @(negedge CLOCK_50);
    core_finish = 1'b0; core_result = 17'd0;
    chk("fin result", result, 32'h1ABCD);
    chk("fin result_valid", result_valid, 32'd1);
    chk("fin cycles", cycles, 32'd10);
    chk("fin busy", busy, 32'd0);
    chk("fin core_rst_n", core_rst_n, 32'd0);

    // Start mid-RUN is ignored; reset mid-RUN clears everything
    begin_run(lows);
    core_iowrite = 1'b1; core_ioaddr = 14'h123; core_iowd = 14'h2AA;
    repeat (3) @(negedge CLOCK_50);
    core_iowrite = 1'b0;
    start = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0;
    chk("midstart cycles", cycles, 32'd5);
    chk("midstart core_rst_n", core_rst_n, 32'd1);
    reset_n = 1'b0;
    @(negedge CLOCK_50);
    reset_n = 1'b1;
    chk("midrst busy", busy, 32'd0);
    chk("midrst result", result, 32'd0);
    chk("midrst cycles", cycles, 32'd0);
    chk("midrst io_valid", io_valid, 32'd0);
    chk("midrst io_data", io_data, 32'd0);

    // Timeout after 20 RUN cycles, then a start clears timed_out
    begin_run(lows);
    repeat (20) @(negedge CLOCK_50);
    chk("tmo timed_out", timed_out, 32'd1);
    chk("tmo cycles", cycles, 32'd20);
    chk("tmo result_valid", result_valid, 32'd0);
    chk("tmo core_rst_n", core_rst_n, 32'd0);
    begin_run(lows);
    chk("restart hold_len", lows, 32'd4);
    chk("restart timed_out", timed_out, 32'd0);

    // Finish coincident with the timeout condition
    repeat (19) @(negedge CLOCK_50);
    core_finish = 1'b1; core_result = 17'h0F0F0;
    @(negedge CLOCK_50);
    core_finish = 1'b0;
    chk("coinc timed_out", timed_out, 32'd0);
    chk("coinc result", result, 32'h0F0F0);
    chk("coinc result_valid", result_valid, 32'd1);
    chk("coinc busy", busy, 32'd0);

    // Ten writes into an 8-deep FIFO with no consumer
    begin_run(lows);
    for (int i = 0; i < 10; i++) begin
      a = 14'(i);
      core_iowrite = 1'b1; core_ioaddr = a; core_iowd = ~a;
      @(negedge CLOCK_50);
    end
    core_iowrite = 1'b0;
    chk("ovf io_overflow", io_overflow, 32'd1);
    io_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a = 14'(i);
      chk("drain io_data", io_data, {4'd0, a, ~a});
      @(negedge CLOCK_50);
    end
    io_ready = 1'b0;
    chk("drain io_valid", io_valid, 32'd0);
    wait_not_busy();

    // Full FIFO with simultaneous push and pop
    begin_run(lows);
    for (int i = 0; i < 8; i++) begin
      a = 14'(i);
      core_iowrite = 1'b1; core_ioaddr = a; core_iowd = ~a;
      @(negedge CLOCK_50);
    end
    core_ioaddr = 14'd8; core_iowd = ~14'd8; io_ready = 1'b1;
    @(negedge CLOCK_50);
    core_iowrite = 1'b0; io_ready = 1'b0;
    chk("pp io_overflow", io_overflow, 32'd0);
    chk("pp io_data", io_data, {4'd0, 14'd1, ~14'd1});
    n = 0;
    io_ready = 1'b1;
    while (io_valid === 1'b1 && n < 20) begin
      n++;
      @(negedge CLOCK_50);
    end
    io_ready = 1'b0;
    chk("pp occupancy", n, 32'd8);
    wait_not_busy();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      reset_n      = ($urandom_range(0, 299) != 0);
      start        = ($urandom_range(0, 39) == 0);
      core_finish  = ($urandom_range(0, 29) == 0);
      core_result  = 17'($urandom);
      core_iowrite = 1'($urandom_range(0, 1));
      core_ioaddr  = 14'($urandom);
      core_iowd    = 14'($urandom);
      io_ready     = ($urandom_range(0, 2) == 0);
      @(negedge CLOCK_50);
    end

    check_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
